gearbox_param: RTL

GEARBOX_PARAM -- requirements
Module: gearbox_param

---
 rtl/gearbox_pkg.sv | 25 ++
 rtl/gearbox_bitbuf.sv | 51 +++++
 rtl/gearbox_param.sv | 77 +++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// Shared types and width helpers for the parameterized bit gearbox.
package gearbox_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int buf_width(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

    // Level must represent 0..BUF_W inclusive.
    function automatic int lvl_width(input int in_w, input int out_w);
        return clog2(in_w + out_w + 1);
    endfunction

endpackage

// File: rtl/gearbox_bitbuf.sv
// Bit buffer datapath: drains OUT_W bits from the bottom, appends IN_W bits at the fill level.
module gearbox_bitbuf
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 132,
    parameter int OUT_W = 128,
    parameter int BUF_W = 260,
    parameter int LVL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_fire,
    input  logic [IN_W-1:0]  in_data,
    input  logic             out_fire,
    input  logic             clear,
    output logic [BUF_W-1:0] bits_q,
    output logic [LVL_W-1:0] cnt,
    output logic [LVL_W-1:0] cnt_nxt
);

    logic [BUF_W-1:0] bits_n;
    logic [BUF_W-1:0] shifted;
    logic [LVL_W-1:0] base;

    // Bits above cnt are kept at zero, so inserting with OR is safe.
    always_comb begin
        shifted = out_fire ? (bits_q >> OUT_W) : bits_q;
        base    = out_fire ? (cnt - LVL_W'(OUT_W)) : cnt;
        bits_n  = shifted;
        cnt_nxt = base;
        if (in_fire) begin
            bits_n  = shifted | (BUF_W'(in_data) << base);
            cnt_nxt = base + LVL_W'(IN_W);
        end
        if (clear) begin
            bits_n  = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
            cnt    <= '0;
        end else begin
            bits_q <= bits_n;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: rtl/gearbox_param.sv
// IN_W -> OUT_W bit-stream gearbox with valid/ready on both sides and a flush that
// emits the residual bits as a zero-padded final word.
module gearbox_param
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 132,
    parameter int OUT_W = 128
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [IN_W-1:0]                     i_data,
    input  logic                                i_flush,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [OUT_W-1:0]                    o_data,
    output logic                                o_last,
    output logic [lvl_width(IN_W, OUT_W)-1:0]   o_level
);

    localparam int BUF_W = buf_width(IN_W, OUT_W);
    localparam int LVL_W = lvl_width(IN_W, OUT_W);
    localparam logic [LVL_W-1:0] OUT_L = LVL_W'(OUT_W);

    state_e           state, state_n;
    logic [BUF_W-1:0] bits;
    logic [LVL_W-1:0] cnt, cnt_nxt;
    logic             in_fire, out_fire, clear;
    logic [OUT_W-1:0] ones, mask;

    assign ones = '1;
    assign mask = ~(ones << cnt);

    // Handshake depends only on registered state, never on i_valid.
    assign o_ready  = (state == RUN) && (cnt <= OUT_L);
    assign o_valid  = (state == RUN) ? (cnt >= OUT_L) : (cnt != '0);
    assign o_last   = (state == FLUSH) && (cnt <= OUT_L);
    assign o_data   = (state == FLUSH) ? (bits[OUT_W-1:0] & mask) : bits[OUT_W-1:0];
    assign o_level  = cnt;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign clear    = (state == FLUSH) & out_fire & o_last;

    gearbox_bitbuf #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .BUF_W(BUF_W),
        .LVL_W(LVL_W)
    ) u_bitbuf (
        .clk     (i_clk),
        .rst     (i_rst),
        .in_fire (in_fire),
        .in_data (i_data),
        .out_fire(out_fire),
        .clear   (clear),
        .bits_q  (bits),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= RUN;
        else       state <= state_n;
    end

    // A flush that would leave nothing buffered is dropped.
    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (i_flush && (cnt_nxt != '0)) state_n = FLUSH;
            FLUSH:   if (clear) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

endmodule
